pdp8_iot_ctl: RTL and testbench
===============================

// Module: pdp8_iot_ctl
// PURPOSE
//  CPU-side initiator of the PDP-8 IOT bus; peripherals (KW8/I clock, TTY, ...) are responders.
//  Runs the free-running F0..F3 phase sequence and drives iot/io_select/mb for one IOT per request.
//  Collects OR'd device skip/selected/interrupt and returns skip to the CPU.
//  Executes CPU-internal device-00 IOTs (ION/IOF/SKON/CAF) and owns interrupt enable plus request/ack.
// PARAMETERS
//  CPU_DEV   6'o00  device code decoded internally; never drives iot to the bus
//  ILL_FLAG  1      1 = pulse iot_nodev when an external IOT sees no io_selected in F1
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, synchronous, active-high
//  iot_req       in   1   CPU request: execute IOT in instr (level, held until iot_done)
//  instr         in   12  IOT instruction word; instr[11:9] must be 3'o6
//  instr_done    in   1   1-cycle pulse at every instruction boundary
//  int_ack       in   1   CPU has taken the interrupt (forces JMS 0)
//  io_selected   in   1   OR of device select responses (valid in F1)
//  io_skip       in   1   OR of device skip responses (valid in F1)
//  io_interrupt  in   1   OR of device interrupt lines
//  state         out  4   bus phase F0=0,F1=1,F2=2,F3=3
//  iot           out  1   external IOT active (F0..F3 of the execution cycle)
//  mb            out  12  instruction word on the bus while iot=1, else 0
//  io_select     out  6   instr[8:3] while iot=1, else 0
//  iot_done      out  1   1-cycle pulse in F3 of the execution cycle
//  skip          out  1   valid with iot_done: CPU increments PC
//  iot_nodev     out  1   1-cycle pulse with iot_done when no device responded
//  ion           out  1   interrupt enable
//  int_req       out  1   interrupt request to CPU sequencer
//  caf           out  1   1-cycle clear-all-flags pulse to all devices
// BEHAVIOUR
//  Reset: state=F0, iot=0, mb=0, io_select=0, iot_done=0, skip=0, iot_nodev=0,
//   ion=0, ion_dly=0, int_req=0, caf=0; any in-flight IOT is abandoned with no iot_done.
//  Phase: state advances F0->F1->F2->F3->F0 every clk, never stalls.
//  Accept: iot_req sampled in F3 (or as reset releases); execution cycle = following F0..F3.
//   Latency: req seen in F3 -> iot_done 4 clks later. Req arriving in F0..F2 waits for next F3.
//  External IOT (instr[8:3]!=CPU_DEV): iot=1, mb=instr, io_select=instr[8:3] for F0..F3.
//   skip = io_skip registered at end of F1. iot_nodev = ILL_FLAG & ~io_selected (F1 sample).
//  Internal IOT (device CPU_DEV): iot stays 0, bus idle; decode instr[2:0] in F1, act in F3:
//   0 SKON: skip=ion, then ion=0.  1 ION: ion_dly=1.  2 IOF: ion=0, ion_dly=0.
//   7 CAF: ion=0, ion_dly=0, caf=1 for one clk.  3..6: no-op, skip=0.
//   iot_done still pulses in F3; iot_nodev never pulses.
//  ION delay: ion_dly sets ion at the first instr_done after the ION completes,
//   so the instruction following ION executes before any interrupt.
//  int_req = ion & ~ion_dly & io_interrupt, registered (1 clk lag); held while true.
//  int_ack: ion=0 next clk; int_req drops next clk. int_ack and ION completing in the
//   same clk: ack wins (ion=0, ion_dly=0).
//  Simultaneous instr_done and IOF: ion ends 0.
//  iot_req dropped mid-cycle: execution completes; iot_done still pulses.
//  Back-to-back: req held through iot_done starts a new cycle at the next F0 (gap 0).
//  Width: io_select = instr[8:3] exactly; mb is not modified.
// STRUCTURE
//  Shared pkg pdp8_defs: phase codes F0..F3, IOT opcode 3'o6, internal sub-op codes
//   SKON/ION/IOF/CAF, CPU_DEV default.
//  Sub-module pdp8_int_ctl: ion/ion_dly/int_req/int_ack logic.
//   Top: phase counter, accept/execute FSM (IDLE, EXEC), bus drive.
// TESTING
//  Free-run after reset: state cycles 0,1,2,3,0..., iot=0, mb=0, all pulses 0.
//  Req instr=12'o6133 in F2, stub asserts io_selected+io_skip in F1 ->
//   mb=6133, io_select=6'o13 for 4 clks; iot_done+skip at F3 of that cycle.
//  instr=12'o6201 with stub silent -> iot_done, skip=0, iot_nodev=1.
//  ION (6001), then io_interrupt=1 -> int_req stays 0 until the 2nd instr_done;
//   int_ack -> ion=0, int_req=0.
//  SKON (6000) with ion=1 -> skip=1, ion=0. CAF (6007) -> caf single pulse, iot=0 throughout.
//  Reset asserted in F1 of an external IOT -> no iot_done; iot=0 and state=F0 next clk.

Source files
------------

// File: rtl/pdp8_defs.sv
//------------------------------------------------------------------------------
// Module : pdp8_defs
// Brief  : Shared PDP-8 IOT bus definitions: phases, opcodes, internal sub-ops.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pdp8_defs;

   localparam logic [1:0] PH_F0 = 2'd0;
   localparam logic [1:0] PH_F1 = 2'd1;
   localparam logic [1:0] PH_F2 = 2'd2;
   localparam logic [1:0] PH_F3 = 2'd3;

   localparam logic [2:0] IOT_OP = 3'o6;

   localparam logic [2:0] OP_SKON = 3'd0;
   localparam logic [2:0] OP_ION  = 3'd1;
   localparam logic [2:0] OP_IOF  = 3'd2;
   localparam logic [2:0] OP_CAF  = 3'd7;

   localparam logic [5:0] CPU_DEV_DFLT = 6'o00;

   localparam logic [0:0] FSM_IDLE = 1'b0;
   localparam logic [0:0] FSM_EXEC = 1'b1;

   typedef struct packed {
      logic skon;
      logic ion;
      logic iof;
      logic caf;
   } int_op_t;

   // Sub-ops 3..6 decode to all-zero, i.e. a no-op that never skips.
   function automatic int_op_t decode_int_op(input logic [2:0] sub);
      int_op_t o;
      o = '0;
      case (sub)
         OP_SKON: o.skon = 1'b1;
         OP_ION:  o.ion  = 1'b1;
         OP_IOF:  o.iof  = 1'b1;
         OP_CAF:  o.caf  = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pdp8_int_ctl.sv
//------------------------------------------------------------------------------
// Module : pdp8_int_ctl
// Brief  : Interrupt enable with one-instruction ION delay, request and ack.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pdp8_int_ctl
   import pdp8_defs::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    instr_done,
   input  logic    int_ack,
   input  logic    io_interrupt,
   input  logic    act,
   input  int_op_t op,
   output logic    ion,
   output logic    int_req
);

   logic ion_q,     ion_d;
   logic ion_dly_q, ion_dly_d;
   logic int_req_q, int_req_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         ion_q     <= 1'b0;
         ion_dly_q <= 1'b0;
         int_req_q <= 1'b0;
      end else begin
         ion_q     <= ion_d;
         ion_dly_q <= ion_dly_d;
         int_req_q <= int_req_d;
      end
   end

   // Later assignments take priority: IOT action over the delayed enable,
   // and int_ack over everything.
   always_comb begin
      ion_d     = ion_q;
      ion_dly_d = ion_dly_q;
      if (instr_done && ion_dly_q) begin
         ion_d     = 1'b1;
         ion_dly_d = 1'b0;
      end
      if (act) begin
         if (op.ion)
            ion_dly_d = 1'b1;
         if (op.skon || op.iof || op.caf)
            ion_d = 1'b0;
         if (op.iof || op.caf)
            ion_dly_d = 1'b0;
      end
      if (int_ack) begin
         ion_d     = 1'b0;
         ion_dly_d = 1'b0;
      end
      int_req_d = ion_q & ~ion_dly_q & io_interrupt & ~int_ack;
   end

   assign ion     = ion_q;
   assign int_req = int_req_q;

endmodule

`default_nettype wire

// File: rtl/pdp8_iot_ctl.sv
//------------------------------------------------------------------------------
// Module : pdp8_iot_ctl
// Brief  : CPU-side IOT bus initiator: F0..F3 phasing, bus drive, device-00 IOTs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pdp8_iot_ctl
   import pdp8_defs::*;
#(
   parameter logic [5:0] CPU_DEV  = CPU_DEV_DFLT,
   parameter bit         ILL_FLAG = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iot_req,
   input  logic [11:0] instr,
   input  logic        instr_done,
   input  logic        int_ack,
   input  logic        io_selected,
   input  logic        io_skip,
   input  logic        io_interrupt,
   output logic [3:0]  state,
   output logic        iot,
   output logic [11:0] mb,
   output logic [5:0]  io_select,
   output logic        iot_done,
   output logic        skip,
   output logic        iot_nodev,
   output logic        ion,
   output logic        int_req,
   output logic        caf
);

   logic [1:0]  phase_q, phase_d;
   logic [0:0]  fsm_q,   fsm_d;
   logic [11:0] instr_q, instr_d;
   logic        ext_q,   ext_d;
   logic        sel_q,   sel_d;
   logic        skp_q,   skp_d;
   int_op_t     op_q,    op_d;

   logic        exec;
   logic        int_act;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= PH_F0;
         fsm_q   <= FSM_IDLE;
         instr_q <= '0;
         ext_q   <= 1'b0;
         sel_q   <= 1'b0;
         skp_q   <= 1'b0;
         op_q    <= '0;
      end else begin
         phase_q <= phase_d;
         fsm_q   <= fsm_d;
         instr_q <= instr_d;
         ext_q   <= ext_d;
         sel_q   <= sel_d;
         skp_q   <= skp_d;
         op_q    <= op_d;
      end
   end

   // The instruction is latched at acceptance so the CPU may drop or change
   // its request once the execution cycle has begun.
   always_comb begin
      phase_d = phase_q + 2'd1;
      fsm_d   = fsm_q;
      instr_d = instr_q;
      ext_d   = ext_q;
      sel_d   = sel_q;
      skp_d   = skp_q;
      op_d    = op_q;
      if (phase_q == PH_F3) begin
         fsm_d = iot_req ? FSM_EXEC : FSM_IDLE;
         if (iot_req) begin
            instr_d = instr;
            ext_d   = (instr[8:3] != CPU_DEV);
         end
      end
      if ((fsm_q == FSM_EXEC) && (phase_q == PH_F1)) begin
         sel_d = io_selected;
         skp_d = io_skip;
         op_d  = ext_q ? '0 : decode_int_op(instr_q[2:0]);
      end
   end

   always_comb begin
      exec      = (fsm_q == FSM_EXEC);
      iot       = exec & ext_q;
      mb        = iot ? instr_q : 12'd0;
      io_select = iot ? instr_q[8:3] : 6'd0;
      iot_done  = exec & (phase_q == PH_F3);
      int_act   = iot_done & ~ext_q;
      skip      = iot_done & (ext_q ? skp_q : (op_q.skon & ion));
      iot_nodev = iot_done & ext_q & ILL_FLAG & ~sel_q;
      caf       = int_act & op_q.caf;
      state     = {2'b00, phase_q};
   end

   pdp8_int_ctl u_int_ctl (
      .clk          (clk),
      .reset        (reset),
      .instr_done   (instr_done),
      .int_ack      (int_ack),
      .io_interrupt (io_interrupt),
      .act          (int_act),
      .op           (op_q),
      .ion          (ion),
      .int_req      (int_req)
   );

endmodule

`default_nettype wire

// File: tb/tb_pdp8_iot_ctl.sv
//------------------------------------------------------------------------------
// Module : tb_pdp8_iot_ctl
// Brief  : Scoreboard bench for pdp8_iot_ctl with a behavioural interrupt model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pdp8_iot_ctl;
   import pdp8_defs::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iot_req = 1'b0;
   logic [11:0] instr = 12'd0;
   logic        instr_done = 1'b0;
   logic        int_ack = 1'b0;
   logic        io_selected;
   logic        io_skip;
   logic        io_interrupt = 1'b0;
   logic [3:0]  state;
   logic        iot;
   logic [11:0] mb;
   logic [5:0]  io_select;
   logic        iot_done;
   logic        skip;
   logic        iot_nodev;
   logic        ion;
   logic        int_req;
   logic        caf;

   logic stub_sel = 1'b0;
   logic stub_skp = 1'b0;

   always #5 clk = ~clk;

   pdp8_iot_ctl dut (
      .clk(clk), .reset(reset), .iot_req(iot_req), .instr(instr),
      .instr_done(instr_done), .int_ack(int_ack), .io_selected(io_selected),
      .io_skip(io_skip), .io_interrupt(io_interrupt), .state(state), .iot(iot),
      .mb(mb), .io_select(io_select), .iot_done(iot_done), .skip(skip),
      .iot_nodev(iot_nodev), .ion(ion), .int_req(int_req), .caf(caf)
   );

   // Device stub answers only during F1 of an external IOT.
   assign io_selected = (iot && state == 4'd1) ? stub_sel : 1'b0;
   assign io_skip     = (iot && state == 4'd1) ? stub_skp : 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit rst_seen = 1'b1;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event missing (cycle %0d)", nm, cyc);
   endtask

   // Reference model state: interrupt enable and pending ION delay.
   bit ion_m = 1'b0;
   bit pend_m = 1'b0;
   bit irq_m = 1'b0;

   typedef struct {
      logic [11:0] ins;
      bit          ext;
      bit          skp;
      bit          nodev;
      bit          cf;
      int          done_cyc;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t predict(input logic [11:0] ins, input bit sel, input bit skp_in);
      exp_t e;
      e.ins      = ins;
      e.ext      = (ins[8:3] != 6'o00);
      e.done_cyc = 0;
      if (e.ext) begin
         e.skp   = skp_in;
         e.nodev = !sel;
         e.cf    = 1'b0;
      end else begin
         e.skp   = (ins[2:0] == 3'd0) && ion_m;
         e.nodev = 1'b0;
         e.cf    = (ins[2:0] == 3'd7);
      end
      return e;
   endfunction

   task automatic model_idone();
      if (pend_m) begin
         ion_m  = 1'b1;
         pend_m = 1'b0;
      end
   endtask

   task automatic model_done(input logic [11:0] ins, input bit with_idone);
      if (with_idone)
         model_idone();
      if (ins[8:3] == 6'o00) begin
         case (ins[2:0])
            3'd0: ion_m = 1'b0;
            3'd1: pend_m = 1'b1;
            3'd2, 3'd7: begin ion_m = 1'b0; pend_m = 1'b0; end
            default: ;
         endcase
      end
   endtask

   // Monitor: phase sequence, bus contents and completion against scoreboard.
   logic [1:0] prev_ph = 2'd0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_seen) begin
         check("rst_state", 32'(state), 32'd0);
         check("rst_quiet", 32'({iot, iot_done, caf, skip, iot_nodev}), 32'd0);
      end else begin
         check("phase_seq", 32'(state), 32'({2'b00, prev_ph + 2'd1}));
         if (iot) begin
            if (sb.size() == 0)
               fail_now("bus_unexpected");
            else begin
               check("bus_ext", 32'(sb[0].ext), 32'd1);
               check("mb", 32'(mb), 32'(sb[0].ins));
               check("io_select", 32'(io_select), 32'(sb[0].ins[8:3]));
            end
         end else
            check("bus_idle", 32'({mb, io_select}), 32'd0);
         if (iot_done) begin
            if (sb.size() == 0)
               fail_now("done_unexpected");
            else begin
               e = sb.pop_front();
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
               check("skip", 32'(skip), 32'(e.skp));
               check("iot_nodev", 32'(iot_nodev), 32'(e.nodev));
               check("caf", 32'(caf), 32'(e.cf));
            end
         end else
            check("pulse_idle", 32'({caf, skip, iot_nodev}), 32'd0);
      end
      prev_ph = state[1:0];
   end

   task automatic wait_f3();
      int n = 0;
      while (state != 4'd3 && n < 8) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (!iot_done && n < 8) begin
         @(negedge clk);
         n++;
      end
      ok = iot_done;
      if (!ok)
         fail_now("iot_done_timeout");
   endtask

   // One IOT from request to instruction boundary, then a settled-state check.
   task automatic run_iot(input logic [11:0] ins, input bit sel, input bit skp_in,
                          input bit early_drop, input int extra_idone);
      exp_t e;
      bit   ok;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      stub_sel = sel;
      stub_skp = skp_in;
      instr    = ins;
      iot_req  = 1'b1;
      wait_f3();
      e = predict(ins, sel, skp_in);
      e.done_cyc = cyc + 4;
      sb.push_back(e);
      @(negedge clk);
      instr = 12'($urandom);
      if (early_drop)
         iot_req = 1'b0;
      wait_done(ok);
      iot_req    = 1'b0;
      instr_done = 1'b1;
      model_done(ins, 1'b1);
      @(negedge clk);
      instr_done = 1'b0;
      if (extra_idone == 1 || (extra_idone == 2 && $urandom_range(0, 1) == 1)) begin
         @(negedge clk);
         instr_done = 1'b1;
         model_idone();
         @(negedge clk);
         instr_done = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      check("ion", 32'(ion), 32'(ion_m));
      check("int_req", 32'(int_req), 32'(ion_m & ~pend_m & irq_m));
   endtask

   initial begin
      exp_t e;
      bit   ok;
      logic [5:0] dev;

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({iot, mb, io_select, iot_done, ion, int_req, caf}), 32'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      run_iot({IOT_OP, 6'o13, 3'o3}, 1'b1, 1'b1, 1'b0, 0);
      run_iot({IOT_OP, 6'o20, 3'o1}, 1'b0, 1'b0, 1'b0, 0);

      // ION delay and int_ack
      irq_m = 1'b1;
      io_interrupt = 1'b1;
      run_iot({IOT_OP, 6'o00, OP_ION}, 1'b0, 1'b0, 1'b0, 0);
      check("int_req_masked", 32'(int_req), 32'd0);
      instr_done = 1'b1;
      model_idone();
      @(negedge clk);
      instr_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ion_on", 32'(ion), 32'd1);
      check("int_req_on", 32'(int_req), 32'd1);
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
      ion_m = 1'b0;
      check("ack_ion", 32'(ion), 32'd0);
      check("ack_int_req", 32'(int_req), 32'd0);

      // SKON with ion set, then CAF
      run_iot({IOT_OP, 6'o00, OP_ION}, 1'b0, 1'b0, 1'b0, 1);
      run_iot({IOT_OP, 6'o00, OP_SKON}, 1'b0, 1'b0, 1'b0, 0);
      run_iot({IOT_OP, 6'o00, OP_ION}, 1'b0, 1'b0, 1'b0, 1);
      run_iot({IOT_OP, 6'o00, OP_CAF}, 1'b0, 1'b0, 1'b0, 0);
      run_iot({IOT_OP, 6'o13, 3'o3}, 1'b1, 1'b1, 1'b1, 0);

      // Back-to-back: request held through iot_done
      @(negedge clk);
      stub_sel = 1'b1;
      stub_skp = 1'b0;
      instr    = {IOT_OP, 6'o24, 3'o5};
      iot_req  = 1'b1;
      wait_f3();
      e = predict(instr, 1'b1, 1'b0);
      e.done_cyc = cyc + 4;
      sb.push_back(e);
      @(negedge clk);
      wait_done(ok);
      model_done({IOT_OP, 6'o24, 3'o5}, 1'b0);
      instr = {IOT_OP, 6'o31, 3'o2};
      stub_skp = 1'b1;
      e = predict(instr, 1'b1, 1'b1);
      e.done_cyc = cyc + 4;
      sb.push_back(e);
      @(negedge clk);
      wait_done(ok);
      iot_req = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during F1 of an external IOT abandons it
      stub_sel = 1'b1;
      instr    = {IOT_OP, 6'o13, 3'o3};
      iot_req  = 1'b1;
      wait_f3();
      e = predict(instr, 1'b1, 1'b0);
      e.done_cyc = cyc + 4;
      sb.push_back(e);
      @(negedge clk);
      @(negedge clk);
      check("abort_in_f1", 32'(state), 32'd1);
      reset   = 1'b1;
      iot_req = 1'b0;
      @(negedge clk);
      sb.delete();
      check("abort_iot", 32'(iot), 32'd0);
      check("abort_done", 32'(iot_done), 32'd0);
      reset  = 1'b0;
      ion_m  = 1'b0;
      pend_m = 1'b0;
      repeat (6) @(negedge clk);

      // Randomised traffic
      for (int i = 0; i < 60; i++) begin
         irq_m        = 1'($urandom);
         io_interrupt = irq_m;
         dev = ($urandom_range(0, 2) == 0) ? 6'o00 : 6'($urandom_range(1, 63));
         run_iot({IOT_OP, dev, 3'($urandom)}, 1'($urandom), 1'($urandom),
                 1'($urandom), 2);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
